du_word_serializer: RTL
=======================

Name: du_word_serializer

Overview:
- Turns one 32-bit debug word (PC value, register-bank entry or data-memory word) into a stream of UART bytes.
- Sits between the debug unit's word source and the UART transmitter. It drives the UART tx_data/tx_start inputs and consumes its tx_done tick.
- Each word is sent MSB-first, one byte per UART transaction. A watchdog aborts the word if the UART stops acknowledging.

Parameters:
BYTE, 8, UART byte width.
DWORD, 32, word width; must be a multiple of BYTE.
NB_TIMEOUT, 20, watchdog counter width; abort after 2^NB_TIMEOUT-1 cycles without i_tx_done.

Ports:
i_clock  input  1  system clock (clk_wiz domain, 50 MHz).
i_reset  input  1  synchronous, active-high reset.
i_word_valid  input  1  word available on i_word.
i_word  input  DWORD  word to transmit.
o_word_ready  output  1  high only in IDLE; a word is accepted on a clock edge where i_word_valid && o_word_ready.
i_tx_done  input  1  one-cycle tick from the UART: current byte finished.
o_tx_data  output  BYTE  byte presented to the UART.
o_tx_start  output  1  one-cycle pulse requesting the UART to send o_tx_data.
o_busy  output  1  high in every state except IDLE.
o_word_done  output  1  one-cycle pulse after the last byte of a word is acknowledged.
o_error  output  1  sticky watchdog-abort flag.

Behaviour:
- One clock; reset is synchronous and active-high (i_clock, i_reset). Reset has priority over everything, including a word in flight.
- Reset values:
  - state = IDLE, so o_word_ready = 1 from the first cycle after reset.
  - o_tx_data = 0, o_tx_start = 0, o_busy = 0, o_word_done = 0, o_error = 0.
  - Shift register, byte counter and watchdog counter = 0.
- Derived: NB_BYTES = DWORD/BYTE; the byte counter is $clog2(NB_BYTES) bits wide, minimum 1.
- IDLE:
  - On accept, load the shift register with i_word, clear the byte counter, clear the watchdog and clear o_error, then go to START.
  - i_word is sampled only on the accept edge.
- START (1 cycle):
  - o_tx_start = 1; o_tx_data = shift register [DWORD-1 -: BYTE].
  - Next state is WAIT.
- WAIT:
  - o_tx_data is held stable and o_tx_start = 0. The watchdog increments every cycle.
  - On i_tx_done, if the byte counter equals NB_BYTES-1, go to DONE.
  - On i_tx_done otherwise, shift the register left by BYTE, increment the byte counter, clear the watchdog and go to START.
  - If the watchdog reaches all-ones with no i_tx_done, set o_error = 1 and go to IDLE. o_word_done is not pulsed in this case.
  - If i_tx_done and the timeout occur in the same cycle, i_tx_done wins.
- DONE (1 cycle): o_word_done = 1, then go to IDLE.
- i_tx_done is ignored in IDLE, START and DONE. i_word_valid is ignored outside IDLE, so the producer must hold the word until it is accepted.
- Latency:
  - Accept at edge k gives o_tx_start high in cycle k+1.
  - tx_done in cycle m gives the next o_tx_start in cycle m+1.
  - The last tx_done in cycle m gives o_word_done in cycle m+1 and o_word_ready in cycle m+2.
- Per word: exactly NB_BYTES o_tx_start pulses, byte order most-significant first.
- o_tx_data holds its last value in IDLE and DONE (it is not cleared except by reset).
- o_error stays set until reset or the next accepted word.

Test Plan:
- Reset, then i_word = 0xDEADBEEF with valid for 1 cycle. Model UART tx_done 10 cycles after each start. Required:
  - o_tx_data at the four starts = 0xDE, 0xAD, 0xBE, 0xEF.
  - Exactly 4 o_tx_start pulses.
  - One o_word_done pulse, 1 cycle after the 4th tx_done.
  - o_word_ready returns 1 cycle after that.
- Back-to-back: valid held high with 0x01234567, then 0x89ABCDEF. Required: 8 bytes 01 23 45 67 89 AB CD EF in order; the second word is accepted on the first IDLE cycle after DONE.
- Change i_word while busy, and assert i_tx_done while in IDLE. Required: the bytes in flight are unchanged, and the spurious tick has no effect (no start, no done).
- Watchdog, with NB_TIMEOUT = 4 for sim: send a word, then never assert tx_done. Required:
  - o_error rises 15 cycles after WAIT is entered, and the block returns to IDLE with no o_word_done.
  - The next word clears o_error and transmits normally.
- Assert i_reset in WAIT of byte 2. Required: the next cycle shows IDLE, all outputs at reset values and o_word_ready = 1; the following word starts from its MSB byte.
- Same-cycle tx_done and timeout (NB_TIMEOUT = 4, tx_done on cycle 15). Required: the byte advances and o_error stays 0.

Source files
------------

// File: rtl/du_word_serializer.sv
// du_word_serializer: streams one DWORD-bit debug word to the UART, one BYTE per transaction,
// most-significant byte first, aborting the word if the UART stops returning tx_done.
module du_word_serializer #(
   parameter int unsigned BYTE       = 8,
   parameter int unsigned DWORD      = 32,
   parameter int unsigned NB_TIMEOUT = 20
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_word_valid,
   input  logic [DWORD-1:0] i_word,
   output logic             o_word_ready,
   input  logic             i_tx_done,
   output logic [BYTE-1:0]  o_tx_data,
   output logic             o_tx_start,
   output logic             o_busy,
   output logic             o_word_done,
   output logic             o_error
);

   localparam int unsigned NB_BYTES = DWORD / BYTE;
   localparam int unsigned NB_CNT   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
   localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(NB_BYTES - 1);

   typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

   state_e                state_q, state_d;
   logic [DWORD-1:0]      shreg_q, shreg_d, shreg_next;
   logic [NB_CNT-1:0]     cnt_q, cnt_d;
   logic [NB_TIMEOUT-1:0] wdog_q, wdog_d, wdog_inc;
   logic [BYTE-1:0]       tx_data_q, tx_data_d;
   logic                  err_q, err_d;

   assign shreg_next = shreg_q << BYTE;
   assign wdog_inc   = wdog_q + NB_TIMEOUT'(1);

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      wdog_d    = wdog_q;
      tx_data_d = tx_data_q;
      err_d     = err_q;
      unique case (state_q)
         StIdle: begin
            if (i_word_valid) begin
               shreg_d   = i_word;
               cnt_d     = '0;
               wdog_d    = '0;
               err_d     = 1'b0;
               // Latch the MSB byte now so o_tx_data is already valid during START.
               tx_data_d = i_word[DWORD-1 -: BYTE];
               state_d   = StStart;
            end
         end
         StStart: state_d = StWait;
         StWait: begin
            wdog_d = wdog_inc;
            // tx_done takes priority over a timeout landing in the same cycle.
            if (i_tx_done) begin
               if (cnt_q == LAST_BYTE) begin
                  state_d = StDone;
               end else begin
                  shreg_d   = shreg_next;
                  cnt_d     = cnt_q + NB_CNT'(1);
                  wdog_d    = '0;
                  tx_data_d = shreg_next[DWORD-1 -: BYTE];
                  state_d   = StStart;
               end
            end else if (&wdog_inc) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q   <= StIdle;
         shreg_q   <= '0;
         cnt_q     <= '0;
         wdog_q    <= '0;
         tx_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         cnt_q     <= cnt_d;
         wdog_q    <= wdog_d;
         tx_data_q <= tx_data_d;
         err_q     <= err_d;
      end
   end

   assign o_word_ready = (state_q == StIdle);
   assign o_busy       = (state_q != StIdle);
   assign o_tx_start   = (state_q == StStart);
   assign o_word_done  = (state_q == StDone);
   assign o_tx_data    = tx_data_q;
   assign o_error      = err_q;

endmodule
